// File: rtl/restoring_divider_pkg.sv
// Shared arithmetic definitions for the restoring divider.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package restoring_divider_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to count 0..w inclusive
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_cla4_sub.sv
// 4-bit carry-lookahead subtractor slice: diff = a + ~b + cin.
// Latency: purely combinational.
// Backpressure: none; cout chains into the next slice's cin.
module cla4_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] diff,
  output logic       cout
);

  logic [3:0] bn;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    bn   = ~b;
    g    = a & bn;
    p    = a ^ bn;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    diff = p ^ c;
  end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done pulses WIDTH+1 edges after the accepting edge (1 edge for divisor 0).
// Backpressure: start is only honoured while ready=1; it is ignored while busy.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import restoring_divider_pkg::*;

  localparam int            CW    = cnt_width(WIDTH);
  localparam int            NSLC  = WIDTH / 4;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvr;      // captured divisor
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] acc;      // dividend bits shift out the top, quotient bits shift in below

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] trial;
  logic [NSLC:0]    carry;
  logic             borrow;
  logic             take;
  logic [WIDTH-1:0] next_rem;

  // Trial subtractor: chained 4-bit lookahead slices, +1 injected at the bottom
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < NSLC; i++) begin : g_sub
    cla4_sub u_slice (
      .a    (shifted[4*i +: 4]),
      .b    (dvr[4*i +: 4]),
      .cin  (carry[i]),
      .diff (trial[4*i +: 4]),
      .cout (carry[i+1])
    );
  end
  assign borrow = ~carry[NSLC];

  // One restoring step: a lost MSB means the true shifted value already exceeds the divisor
  always_comb begin
    shifted  = {rem[WIDTH-2:0], acc[WIDTH-1]};
    take     = ~borrow | rem[WIDTH-1];
    next_rem = take ? trial : shifted;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvr         <= '0;
      rem         <= '0;
      acc         <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc         <= dividend;
            dvr         <= divisor;
            rem         <= '0;
            cnt         <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            state       <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          rem <= next_rem;
          acc <= {acc[WIDTH-2:0], take};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Publish results; done and ready rise together as we re-enter IDLE
          if (dvr == '0) begin
            quotient    <= '1;
            remainder   <= acc;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= acc;
            remainder   <= rem;
          end
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed, table-driven bench for restoring_divider (WIDTH=8).
// Latency: checks start-to-done cycle counts against hand-computed values.
// Backpressure: exercises start while busy and reset mid-operation.
module tb_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Entered and left at a negedge; start is driven here and accepted on the next posedge.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z,
                         output int lat, output int rdy_bad);
    chk({tag, " ready_before_start"}, ready, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    lat      = 1;
    rdy_bad  = 0;
    chk({tag, " ready_low_after_accept"}, ready, 0);
    chk({tag, " done_single_pulse"}, done, 0);
    chk({tag, " dbz_cleared_on_start"}, div_by_zero, 0);
    while (!done && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (!done && ready) rdy_bad++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  initial begin
    logic [7:0] q, r;
    logic       z;
    int         lat, rdy_bad, done_seen;

    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 10};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 10};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 10};
    vecs[3]  = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 2};
    vecs[4]  = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 10};
    vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 10};
    vecs[6]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 10};
    vecs[7]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 10};
    vecs[8]  = '{8'd1,   8'd0,   8'd255, 8'd1,   1'b1, 2};
    vecs[9]  = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 10};
    vecs[10] = '{8'd255, 8'd200, 8'd1,   8'd55,  1'b0, 10};
    vecs[11] = '{8'd199, 8'd13,  8'd15,  8'd4,   1'b0, 10};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Back-to-back table: each new start is driven in the previous done cycle
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b);
      run_div(tag, vecs[i].a, vecs[i].b, q, r, z, lat, rdy_bad);
      chk({tag, " latency"}, lat, vecs[i].lat);
      chk({tag, " quotient"}, q, vecs[i].q);
      chk({tag, " remainder"}, r, vecs[i].r);
      chk({tag, " div_by_zero"}, z, vecs[i].z);
      chk({tag, " ready_low_while_busy"}, rdy_bad, 0);
    end
    @(posedge clk);
    @(negedge clk);

    // start pulsed during RUN with other operands must be ignored
    chk("busy ready_idle", ready, 1);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    lat      = 1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    while (!done && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("busy latency", lat, 10);
    chk("busy quotient", quotient, 28);
    chk("busy remainder", remainder, 4);
    repeat (3) @(negedge clk);
    chk("hold done_low", done, 0);
    chk("hold quotient", quotient, 28);
    chk("hold remainder", remainder, 4);

    // Reset in the 4th RUN cycle, with start also high to test rst priority
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    chk("midrst ready", ready, 1);
    chk("midrst done", done, 0);
    chk("midrst quotient", quotient, 0);
    chk("midrst remainder", remainder, 0);
    chk("midrst div_by_zero", div_by_zero, 0);
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst no_done_pulse", done_seen, 0);
    run_div("after_rst 9/3", 8'd9, 8'd3, q, r, z, lat, rdy_bad);
    chk("after_rst latency", lat, 10);
    chk("after_rst quotient", q, 3);
    chk("after_rst remainder", r, 0);
    chk("after_rst div_by_zero", z, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
